// File: rtl/piso_word_shift_register_pkg.sv
// Shared types and default sizing for the word shifter family (serial-in and parallel-in variants).
package piso_word_shift_register_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;

endpackage

// File: rtl/piso_word_shift_register_if.sv
// Load and stream handshake bundle for piso_word_shift_register.
// Optional dout_last signal present only when PISO_LAST_FLAG_EN is defined.
interface piso_word_shift_register_if
    import piso_word_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
);
    logic [WIDTH*DEPTH-1:0] par_in;
    logic                   load_valid;
    logic                   load_ready;
    logic [WIDTH-1:0]       dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   busy;
`ifdef PISO_LAST_FLAG_EN
    logic                   dout_last;
`endif

    modport master (
        output par_in, load_valid, dout_ready,
`ifdef PISO_LAST_FLAG_EN
        input  dout_last,
`endif
        input  load_ready, dout, dout_valid, busy
    );

    modport slave (
        input  par_in, load_valid, dout_ready,
`ifdef PISO_LAST_FLAG_EN
        output dout_last,
`endif
        output load_ready, dout, dout_valid, busy
    );

endinterface

// File: rtl/piso_word_shift_register_frame_counter.sv
// Words-remaining counter for one frame; raises last while the final word is on the stream.
module piso_frame_counter
    import piso_word_shift_register_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic last
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= CW'(DEPTH);
        end else if (dec) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign last = (remaining == CW'(1));

endmodule

// File: rtl/piso_word_shift_register.sv
// Parallel-in, serial-out word shifter: emits taps oldest-first (word DEPTH-1 down to 0).
// Define PISO_LAST_FLAG_EN to add dout_last marking word 0 of each frame.
module piso_word_shift_register
    import piso_word_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input logic                        clk,
    input logic                        rst_n,
    piso_word_shift_register_if.slave  bus
);
    piso_state_t      state;
    logic [WIDTH-1:0] w [DEPTH];
    logic             last;
    logic             load_accept;
    logic             xfer;

    // A load may join the final transfer so consecutive frames run without a bubble.
    assign bus.load_ready = (state == IDLE) || ((state == SHIFT) && last && bus.dout_ready);
    assign load_accept    = bus.load_valid && bus.load_ready;
    assign xfer           = (state == SHIFT) && bus.dout_ready;

    assign bus.dout       = w[DEPTH-1];
    assign bus.dout_valid = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);

`ifdef PISO_LAST_FLAG_EN
    assign bus.dout_last  = (state == SHIFT) && last;
`endif

    piso_frame_counter #(
        .DEPTH (DEPTH)
    ) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_accept),
        .dec   (xfer),
        .last  (last)
    );

    // Zeros shift in at word 0, so the top word is already 0 once a frame drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                w[k] <= '0;
            end
        end else if (load_accept) begin
            state <= SHIFT;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                w[k] <= bus.par_in[k*WIDTH +: WIDTH];
            end
        end else if (xfer) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                w[k] <= w[k-1];
            end
            w[0] <= '0;
            if (last) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_piso_word_shift_register.sv
// Directed, table-driven bench for piso_word_shift_register (both PISO_LAST_FLAG_EN builds).
module tb_piso_word_shift_register;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic             lv;
        logic [1:0]       sel;
        logic             dr;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_valid;
        logic             exp_lr;
        logic             exp_busy;
        logic             exp_last;
    } vec_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_F = 2'd2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    vec_t vecs[$];
    logic [WIDTH-1:0] out_a [DEPTH];

    piso_word_shift_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    piso_word_shift_register #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH*DEPTH-1:0] frame(input logic [1:0] sel);
        logic [WIDTH*DEPTH-1:0] f;
        case (sel)
            SEL_A:   f = {16'h000B, 16'h0020, 16'h0050, 16'h0032,
                          16'h00AC, 16'h000C, 16'h000B, 16'h000A};
            SEL_B:   f = {DEPTH{16'h1234}};
            default: f = {DEPTH{16'hFFFF}};
        endcase
        return f;
    endfunction

    task automatic add(input logic lv, input logic [1:0] sel, input logic dr,
                       input logic [WIDTH-1:0] d, input logic v, input logic lr,
                       input logic b, input logic l);
        vec_t x;
        x.lv = lv; x.sel = sel; x.dr = dr;
        x.exp_dout = d; x.exp_valid = v; x.exp_lr = lr; x.exp_busy = b; x.exp_last = l;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] d, input logic v,
                         input logic lr, input logic b, input logic l);
        logic ok;
        n_vec++;
        ok = (bus.dout === d) && (bus.dout_valid === v) &&
             (bus.load_ready === lr) && (bus.busy === b);
`ifdef PISO_LAST_FLAG_EN
        ok = ok && (bus.dout_last === l);
        if (!ok)
            $display("FAIL %s: got dout=%h valid=%b ready=%b busy=%b last=%b, want dout=%h valid=%b ready=%b busy=%b last=%b",
                     name, bus.dout, bus.dout_valid, bus.load_ready, bus.busy, bus.dout_last,
                     d, v, lr, b, l);
`else
        if (!ok)
            $display("FAIL %s: got dout=%h valid=%b ready=%b busy=%b, want dout=%h valid=%b ready=%b busy=%b (last=%b)",
                     name, bus.dout, bus.dout_valid, bus.load_ready, bus.busy, d, v, lr, b, l);
`endif
        if (!ok) n_bad++;
    endtask

    task automatic drive(input logic lv, input logic [1:0] sel, input logic dr);
        bus.load_valid = lv;
        bus.par_in     = frame(sel);
        bus.dout_ready = dr;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        out_a[0] = 16'h000B; out_a[1] = 16'h0020; out_a[2] = 16'h0050; out_a[3] = 16'h0032;
        out_a[4] = 16'h00AC; out_a[5] = 16'h000C; out_a[6] = 16'h000B; out_a[7] = 16'h000A;

        // basic frame, full-rate drain
        add(1, SEL_A, 1, 16'h0000, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, SEL_A, 1, out_a[i], 1, i == 7, 1, i == 7);
        add(0, SEL_A, 1, 16'h0000, 0, 1, 0, 0);

        // backpressure on word 2, then a refused load while the last word stalls
        add(1, SEL_A, 1, 16'h0000, 0, 1, 0, 0);
        add(0, SEL_A, 1, out_a[0], 1, 0, 1, 0);
        add(0, SEL_A, 1, out_a[1], 1, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            add(0, SEL_A, 0, 16'h0050, 1, 0, 1, 0);
        for (int i = 2; i < 7; i++)
            add(0, SEL_A, 1, out_a[i], 1, 0, 1, 0);
        add(1, SEL_B, 0, out_a[7], 1, 0, 1, 1);
        add(0, SEL_A, 1, out_a[7], 1, 1, 1, 1);
        add(0, SEL_A, 1, 16'h0000, 0, 1, 0, 0);

        // back-to-back with load held; 0xFFFF loads mid-frame must be ignored
        add(1, SEL_A, 1, 16'h0000, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, (i >= 2 && i <= 4) ? SEL_F : SEL_B, 1, out_a[i], 1, i == 7, 1, i == 7);
        for (int i = 0; i < 8; i++)
            add(0, SEL_A, 1, 16'h1234, 1, i == 7, 1, i == 7);
        add(0, SEL_A, 1, 16'h0000, 0, 1, 0, 0);
        add(0, SEL_A, 1, 16'h0000, 0, 1, 0, 0);

        rst_n = 1'b0;
        drive(0, SEL_A, 0);
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", 16'h0000, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        foreach (vecs[i]) begin
            #2;
            drive(vecs[i].lv, vecs[i].sel, vecs[i].dr);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_valid,
                  vecs[i].exp_lr, vecs[i].exp_busy, vecs[i].exp_last);
            @(posedge clk);
        end

        // reset mid-frame for 3 cycles, then no stray words
        #2;
        drive(1, SEL_A, 1);
        @(posedge clk);
        #2;
        drive(0, SEL_A, 1);
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_word3", out_a[3], 1, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("reset_hold%0d", i), 16'h0000, 0, 1, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("post_reset%0d", i), 16'h0000, 0, 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
